// File: rtl/instr_fetch_seq_if.sv
// Decoder/ROM-facing bundle of the instruction fetch sequencer.
// master = decoder + ROM side, slave = the sequencer.
interface instr_fetch_seq_if #(parameter int ADDR_W = 10);
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic              fetch_abort;
  logic              cache_inv;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              fetch_busy;
  logic              instr_valid;
  logic [31:0]       instr_out;
  logic              fetch_err;

  modport master (output fetch_req, fetch_pc, fetch_abort, cache_inv, rom_data,
                  input  rom_addr, fetch_busy, instr_valid, instr_out, fetch_err);
  modport slave  (input  fetch_req, fetch_pc, fetch_abort, cache_inv, rom_data,
                  output rom_addr, fetch_busy, instr_valid, instr_out, fetch_err);
endinterface

// File: rtl/instr_fetch_seq.sv
// Fetches four ROM bytes at a PC and returns them as one little-endian word.
// Optional last-fetch buffer enabled by defining FETCH_CACHE_EN.
module instr_fetch_seq #(
  parameter int ADDR_W  = 10,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_seq_if.slave   bus
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ERR, S_HIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [1:0]        k_q, cnt_q;
  logic [ROM_LAT-1:0] pipe_q;
  logic [ROM_LAT:0]  pipe_tmp;
  logic [31:0]       asm_q, instr_q;
  logic              accept, misal, hit, abort_act, issuing, cap;
  logic              valid_o, err_o;
  logic [31:0]       instr_o;

  assign accept    = (state_q == S_IDLE) && bus.fetch_req && !bus.fetch_abort;
  assign misal     = |bus.fetch_pc[1:0];
  assign abort_act = bus.fetch_abort && (state_q inside {S_ISSUE, S_DRAIN, S_DONE});
  assign issuing   = (state_q == S_ISSUE);
  assign cap       = pipe_q[ROM_LAT-1];
  assign pipe_tmp  = {pipe_q, issuing};

`ifdef FETCH_CACHE_EN
  logic [31:0] tag_q, cdata_q, pc_q;
  logic        tag_vld_q;
  // A coincident invalidate forces a miss.
  assign hit = tag_vld_q && !bus.cache_inv && (bus.fetch_pc == tag_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q     <= '0;
      cdata_q   <= '0;
      pc_q      <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      if (accept) pc_q <= bus.fetch_pc;
      if (bus.cache_inv) tag_vld_q <= 1'b0;
      else if (state_q == S_DONE && !bus.fetch_abort) begin
        tag_q     <= pc_q;
        cdata_q   <= asm_q;
        tag_vld_q <= 1'b1;
      end
    end
  end
`else
  logic unused_ok;
  assign hit       = 1'b0;
  assign unused_ok = ^{bus.cache_inv, bus.fetch_pc[31:ADDR_W]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = misal ? S_ERR : (hit ? S_HIT : S_ISSUE);
      S_ISSUE: if (bus.fetch_abort) state_d = S_IDLE;
               else if (k_q == 2'd3) state_d = S_DRAIN;
      S_DRAIN: if (bus.fetch_abort) state_d = S_IDLE;
               else if (cap && cnt_q == 2'd3) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // instr_out shows the new word only while it is being validated; otherwise the held copy.
  always_comb begin
    valid_o = 1'b0;
    err_o   = 1'b0;
    instr_o = instr_q;
    case (state_q)
      S_DONE: if (!bus.fetch_abort) begin valid_o = 1'b1; instr_o = asm_q; end
      S_ERR:  begin valid_o = 1'b1; err_o = 1'b1; instr_o = '0; end
`ifdef FETCH_CACHE_EN
      S_HIT:  begin valid_o = 1'b1; instr_o = cdata_q; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      pipe_q     <= '0;
      asm_q      <= '0;
      instr_q    <= '0;
    end else begin
      if (accept && !misal && !hit) begin
        rom_addr_q <= bus.fetch_pc[ADDR_W-1:0];
        k_q        <= '0;
      end else if (issuing && !bus.fetch_abort) begin
        k_q <= k_q + 2'd1;
        if (k_q != 2'd3) rom_addr_q <= rom_addr_q + ADDR_W'(1);
      end
      // In-flight bytes are dropped on abort by flushing the return pipe.
      pipe_q <= abort_act ? '0 : pipe_tmp[ROM_LAT-1:0];
      if (accept)   cnt_q <= '0;
      else if (cap) cnt_q <= cnt_q + 2'd1;
      if (cap)      asm_q <= {bus.rom_data, asm_q[31:8]};
      if (valid_o)  instr_q <= instr_o;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.fetch_busy  = (state_q != S_IDLE);
  assign bus.instr_valid = valid_o;
  assign bus.instr_out   = instr_o;
  assign bus.fetch_err   = err_o;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Randomized bench for instr_fetch_seq against a byte-array ROM and a transaction-level model.
module tb_instr_fetch_seq;
  localparam int ADDR_W  = 10;
  localparam int ROM_LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_seq_if #(.ADDR_W(ADDR_W)) bus();
  instr_fetch_seq #(.ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0]        rom [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] ah  [0:ROM_LAT-1];
  always @(posedge clk) begin
    ah[0] <= bus.rom_addr;
    for (int i = 1; i < ROM_LAT; i++) ah[i] <= ah[i-1];
  end
  assign bus.rom_data = rom[ah[ROM_LAT-1]];

  int n_tests = 0, n_fail = 0;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_instr, c_tag, c_data, last_pc;
  bit                c_vld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_instr = '0; c_vld = 0; c_tag = '0; c_data = '0;
  endtask

  // One request in cycle 0, then lat+1 observed cycles; abort_at=0 means no abort.
  task automatic fetch(input logic [31:0] pc, input int abort_at, input bit inv);
    bit mis, hit, aborted, abt_now, exp_v;
    int lat;
    logic [ADDR_W-1:0] base, a;
    logic [31:0] exp_i;
    mis = (pc[1:0] != 2'b00);
    base = pc[ADDR_W-1:0];
`ifdef FETCH_CACHE_EN
    hit = !mis && c_vld && !inv && (pc == c_tag);
    if (inv) c_vld = 0;
`else
    hit = 0;
`endif
    lat = (mis || hit) ? 1 : 5 + ROM_LAT;
    exp_i = '0;
    for (int k = 0; k < 4; k++) begin
      a = base + ADDR_W'(k);
      exp_i[8*k +: 8] = rom[a];
    end
    if (mis) exp_i = '0;
    else if (hit) exp_i = c_data;
    aborted = 0;
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_pc = pc; bus.cache_inv = inv; bus.fetch_abort = 1'b0;
    #1 chk("busy_c0", 32'(bus.fetch_busy), 32'd0);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      bus.cache_inv   = 1'b0;
      bus.fetch_abort = (c == abort_at);
      bus.fetch_req   = (c <= lat && (abort_at == 0 || c <= abort_at)) ? 1'($urandom % 2) : 1'b0;
      bus.fetch_pc    = $urandom;
      #1;
      abt_now = !mis && !hit && (c == abort_at);
      exp_v = !aborted && !abt_now && (c == lat);
      chk("valid", 32'(bus.instr_valid), 32'(exp_v));
      chk("busy", 32'(bus.fetch_busy), 32'(!aborted && c <= lat));
      if (exp_v) begin
        chk("instr", bus.instr_out, exp_i);
        chk("err", 32'(bus.fetch_err), 32'(mis));
      end
      if (!mis && !hit && !aborted && c <= 4) m_addr = base + ADDR_W'(c - 1);
      chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
      if (aborted) chk("instr_hold", bus.instr_out, m_instr);
      if (abt_now) aborted = 1;
    end
    bus.fetch_req = 1'b0; bus.fetch_abort = 1'b0;
    if (!aborted) begin
      m_instr = exp_i;
      if (!mis && !hit) begin c_vld = 1; c_tag = pc; c_data = exp_i; end
    end
    last_pc = pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(bus.rom_addr), 32'd0);
    chk({tag, "_busy"},  32'(bus.fetch_busy), 32'd0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"}, bus.instr_out, 32'd0);
    chk({tag, "_err"},   32'(bus.fetch_err), 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    int r, ab;
    rst_n = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_pc = '0; bus.fetch_abort = 1'b0; bus.cache_inv = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'($urandom);
    rom[0] = 8'h13; rom[1] = 8'h00; rom[2] = 8'hA0; rom[3] = 8'h00;
    rom[10'h3FC] = 8'h11; rom[10'h3FD] = 8'h22; rom[10'h3FE] = 8'h33; rom[10'h3FF] = 8'h44;
    model_reset();
    last_pc = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst");
    rst_n = 1'b1;

    fetch(32'h0, 0, 0);
    fetch(32'h3FE, 0, 0);
    fetch(32'h3FC, 0, 0);
    fetch(32'h400, 0, 0);
    fetch(32'h4, 3, 0);
    fetch(32'h8, 0, 0);
    fetch(32'h0, 0, 0);
    fetch(32'h0, 0, 0);
    fetch(32'h0, 0, 1);
    fetch(32'h10, 5 + ROM_LAT, 0);
    fetch(32'h5, 1, 0);

    // Abort beats a simultaneous request in IDLE.
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_abort = 1'b1; bus.fetch_pc = 32'h20;
    @(negedge clk);
    bus.fetch_req = 1'b0; bus.fetch_abort = 1'b0;
    #1 chk("idle_abort_busy", 32'(bus.fetch_busy), 32'd0);
    chk("idle_abort_addr", 32'(bus.rom_addr), 32'(m_addr));

    repeat (80) begin
      r = $urandom % 8;
      if (r == 0)      pc = {$urandom} | 32'h1;
      else if (r < 3)  pc = last_pc;
      else             pc = {$urandom} & ~32'h3;
      ab = ($urandom % 5 == 0) ? int'($urandom_range(1, 5 + ROM_LAT)) : 0;
      fetch(pc, ab, ($urandom % 6) == 0);
    end

    // Reset asserted mid-DRAIN clears everything immediately.
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h3FC;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.fetch_req = 1'b0;
    end
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fetch(32'h0, 0, 0);
    fetch(32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
